// File: rtl/fmap_stream_gen.sv
// Feature-map stimulus source: streams ROWS x COLS x DEPTH frames, NUM_LANES elements per beat.
// Optional running lane checksum enabled by defining FMAP_STREAM_GEN_CHECKSUM_EN.
module fmap_stream_gen #(
    parameter int ROWS       = 25,
    parameter int COLS       = 25,
    parameter int DEPTH      = 8,
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [1:0]                      mode,
    input  logic [DATA_WIDTH-1:0]           seed,
    input  logic [15:0]                     num_frames,
    output logic                            busy,
    output logic                            done,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] m_data,
    output logic                            m_first,
    output logic                            m_last_col,
    output logic                            m_last_row,
    output logic                            m_last_frame,
    output logic [31:0]                     checksum
);

    localparam int DG_N = DEPTH / NUM_LANES;
    localparam int DG_W = (DG_N > 1) ? $clog2(DG_N) : 1;
    localparam int C_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int R_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [DG_W-1:0]         dg_reg, dg_next;
    logic [C_W-1:0]          c_reg, c_next;
    logic [R_W-1:0]          r_reg, r_next;
    logic [15:0]             f_reg, f_next;
    logic [31:0]             e_reg, e_next;
    logic [15:0]             lfsr_reg, lfsr_next;
    logic [1:0]              mode_reg;
    logic [DATA_WIDTH-1:0]   seed_reg;
    logic [15:0]             frames_reg;
    logic [15:0]             seed16;

    logic run, beat_ok, start_ok;
    logic dg_wrap, c_wrap, r_wrap, f_wrap;

    assign seed16   = 16'(seed);
    assign run      = (state_reg == S_RUN);
    assign beat_ok  = run && m_ready;
    assign start_ok = (state_reg == S_IDLE) && start;

    assign dg_wrap = (dg_reg == DG_W'(DG_N - 1));
    assign c_wrap  = (c_reg == C_W'(COLS - 1));
    assign r_wrap  = (r_reg == R_W'(ROWS - 1));
    assign f_wrap  = (f_reg == frames_reg - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            dg_reg     <= '0;
            c_reg      <= '0;
            r_reg      <= '0;
            f_reg      <= '0;
            e_reg      <= '0;
            lfsr_reg   <= '0;
            mode_reg   <= '0;
            seed_reg   <= '0;
            frames_reg <= '0;
        end else begin
            state_reg <= state_next;
            dg_reg    <= dg_next;
            c_reg     <= c_next;
            r_reg     <= r_next;
            f_reg     <= f_next;
            e_reg     <= e_next;
            lfsr_reg  <= lfsr_next;
            if (start_ok) begin
                mode_reg   <= mode;
                seed_reg   <= seed;
                frames_reg <= num_frames;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        dg_next    = dg_reg;
        c_next     = c_reg;
        r_next     = r_reg;
        f_next     = f_reg;
        e_next     = e_reg;
        lfsr_next  = lfsr_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_frames != 16'd0) ? S_RUN : S_DONE;
                    dg_next    = '0;
                    c_next     = '0;
                    r_next     = '0;
                    f_next     = '0;
                    e_next     = '0;
                    lfsr_next  = (seed16 == 16'd0) ? 16'd1 : seed16;
                end
            end
            S_RUN: begin
                if (beat_ok) begin
                    // Galois LFSR, taps 0xB400; free-runs across frame boundaries
                    lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
                    e_next    = e_reg + 32'(NUM_LANES);
                    dg_next   = dg_wrap ? '0 : dg_reg + DG_W'(1);
                    if (dg_wrap) begin
                        c_next = c_wrap ? '0 : c_reg + C_W'(1);
                        if (c_wrap) begin
                            r_next = r_wrap ? '0 : r_reg + R_W'(1);
                            if (r_wrap) begin
                                e_next = '0;
                                f_next = f_wrap ? '0 : f_reg + 16'd1;
                                if (f_wrap)
                                    state_next = S_DONE;
                            end
                        end
                    end
                end
                if (abort) begin
                    state_next = S_IDLE;
                    dg_next    = '0;
                    c_next     = '0;
                    r_next     = '0;
                    f_next     = '0;
                    e_next     = '0;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);
    assign m_valid      = run;
    assign m_first      = run && (r_reg == '0) && (c_reg == '0) && (dg_reg == '0);
    assign m_last_col   = run && c_wrap && dg_wrap;
    assign m_last_row   = m_last_col && r_wrap;
    assign m_last_frame = m_last_row && f_wrap;

    // Lane values are forced to zero outside RUN so idle outputs read as reset state
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] val;
        always_comb begin
            val = '0;
            if (run) begin
                case (mode_reg)
                    2'd0:    val = seed_reg + DATA_WIDTH'(e_reg) + DATA_WIDTH'(gi);
                    2'd1:    val = seed_reg;
                    2'd2:    val = DATA_WIDTH'(lfsr_reg ^ 16'(gi));
                    default: val = DATA_WIDTH'(f_reg);
                endcase
            end
        end
        assign m_data[gi*DATA_WIDTH +: DATA_WIDTH] = val;
    end

`ifdef FMAP_STREAM_GEN_CHECKSUM_EN
    logic [31:0] sum_reg;
    logic [31:0] beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < NUM_LANES; l++)
            beat_sum = beat_sum + 32'(m_data[l*DATA_WIDTH +: DATA_WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum_reg <= '0;
        else if (start_ok)
            sum_reg <= '0;
        else if (beat_ok)
            sum_reg <= sum_reg + beat_sum;
    end

    assign checksum = sum_reg;
`else
    assign checksum = '0;
`endif

endmodule
